clock_time_ctrl: RTL and testbench

//  Sequencer for the HH:MM:SS time-of-day counter. Divides the board clock

---
 rtl/clock_time_ctrl.sv | 101 ++++++++++
 tb/tb_clock_time_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: 1 s tick prescaler, blink strobe and time-set FSM with edit buffer for the HH:MM:SS counter.
// Define CLOCK_CTRL_AUTOREPEAT_EN to add held-key auto-repeat of up/down in the SET_* states.
module clock_time_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int REPEAT_DLY = 25_000_000
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_down,
    input  logic [4:0] cur_h,
    input  logic [5:0] cur_m,
    input  logic [5:0] cur_s,
    output logic       tick_1s,
    output logic       load,
    output logic [4:0] load_h,
    output logic [5:0] load_m,
    output logic [5:0] load_s,
    output logic [1:0] mode,
    output logic       blink
);
    localparam logic [2:0] RUN = 3'd0, SET_H = 3'd1, SET_M = 3'd2, SET_S = 3'd3, COMMIT = 3'd4;
    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [TW-1:0] T_MAX = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] B_MAX = BW'(BLINK_DIV - 1);

    if (TICK_DIV < 4 || BLINK_DIV < 2 || REPEAT_DLY < 1) begin : g_bad_param
        $error("clock_time_ctrl: divider parameter out of range");
    end

    logic [2:0]    state;
    logic [2:0]    k_s1, k_s2, k_d;
    logic [TW-1:0] pre;
    logic [BW-1:0] bcnt;
    logic          p_mode, p_up, p_dn, in_set, step_up, step_dn, edit;

    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top, input logic up);
        return up ? (v == top ? 6'd0 : v + 6'd1) : (v == 6'd0 ? top : v - 6'd1);
    endfunction

    // key vectors are ordered {mode, up, down}
    assign {p_mode, p_up, p_dn} = k_s2 & ~k_d;
    assign in_set  = state == SET_H || state == SET_M || state == SET_S;
    assign mode    = state[1:0];
    assign load    = state == COMMIT;
    assign tick_1s = state == RUN && pre == T_MAX;
    assign edit    = in_set && !p_mode && (step_up ^ step_dn);

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DLY + 1);
    localparam logic [RW-1:0] R_MAX    = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] R_RELOAD = RW'(REPEAT_DLY - BLINK_DIV + 1);
    logic [RW-1:0] rcnt;
    logic          held, rep;
    // rcnt is 0 in the press cycle, so the first repeat lands REPEAT_DLY cycles later
    assign held    = in_set && !p_mode && (k_s2[1] || k_s2[0]);
    assign rep     = held && rcnt == R_MAX;
    assign step_up = p_up || (rep && k_s2[1]);
    assign step_dn = p_dn || (rep && k_s2[0]);
    always_ff @(posedge Clk or negedge reset_n)
        if (!reset_n) rcnt <= '0;
        else rcnt <= !held ? '0 : rep ? R_RELOAD : rcnt + 1'b1;
`else
    assign step_up = p_up;
    assign step_dn = p_dn;
`endif

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RUN;
            k_s1   <= '0;
            k_s2   <= '0;
            k_d    <= '0;
            pre    <= '0;
            bcnt   <= '0;
            blink  <= 1'b0;
            load_h <= '0;
            load_m <= '0;
            load_s <= '0;
        end else begin
            k_s1  <= {key_mode, key_up, key_down};
            k_s2  <= k_s1;
            k_d   <= k_s2;
            pre   <= (state != RUN || pre == T_MAX) ? '0 : pre + 1'b1;
            bcnt  <= (!in_set || p_mode || bcnt == B_MAX) ? '0 : bcnt + 1'b1;
            blink <= (!in_set || p_mode) ? 1'b0 : blink ^ (bcnt == B_MAX);
            state <= state == COMMIT ? RUN : !p_mode ? state : state == SET_S ? COMMIT : state + 3'd1;
            if (state == RUN && p_mode) begin
                load_h <= cur_h;
                load_m <= cur_m;
                load_s <= cur_s;
            end
            if (edit && state == SET_H) load_h <= 5'(wrap_step({1'b0, load_h}, 6'd23, step_up));
            if (edit && state == SET_M) load_m <= wrap_step(load_m, 6'd59, step_up);
            if (edit && state == SET_S) load_s <= wrap_step(load_s, 6'd59, step_up);
        end
    end
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: randomized key sequences against a field-level time-set model, with a scoreboard monitor.
`timescale 1ns/1ps
module tb_clock_time_ctrl;
    localparam int TD = 10, BD = 4, RD = 8;

    logic       Clk = 1'b0, reset_n = 1'b0;
    logic       key_mode = 1'b0, key_up = 1'b0, key_down = 1'b0;
    logic [4:0] cur_h = '0;
    logic [5:0] cur_m = '0, cur_s = '0;
    logic       tick_1s, load, blink;
    logic [4:0] load_h;
    logic [5:0] load_m, load_s;
    logic [1:0] mode;

    clock_time_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD), .REPEAT_DLY(RD)) dut (
        .Clk(Clk), .reset_n(reset_n), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
        .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s), .tick_1s(tick_1s), .load(load),
        .load_h(load_h), .load_m(load_m), .load_s(load_s), .mode(mode), .blink(blink)
    );

    always #5 Clk = ~Clk;

    typedef struct { int at; int h; int m; int s; } snap_t;
    typedef struct { int at; int md; int origin; } ev_t;

    snap_t snap_q[$], load_q[$];
    ev_t   ev_q[$];
    snap_t sp;
    ev_t   ev;
    int    cyc, n_tests, n_fail;
    int    m_mode, b_h, b_m, b_s;
    int    mon_mode, mon_entry, mon_origin;

    // cyc = number of rising edges since reset release
    always @(posedge Clk or negedge reset_n) cyc <= !reset_n ? 0 : cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    // Monitor: applies mode events, checks mode/blink/tick every cycle, pops snapshots and loads.
    always @(negedge Clk) if (reset_n) begin
        while (ev_q.size() > 0 && ev_q[0].at <= cyc) begin
            ev = ev_q.pop_front();
            mon_mode  = ev.md;
            mon_entry = ev.at;
            if (ev.origin >= 0) mon_origin = ev.origin;
        end
        check("mode", int'(mode), mon_mode);
        check("blink", int'(blink), mon_mode != 0 ? ((cyc - mon_entry) / BD) % 2 : 0);
        check("tick_1s", int'(tick_1s), int'(mon_mode == 0 && cyc >= mon_origin && (cyc - mon_origin) % TD == TD - 1));
        while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
            sp = snap_q.pop_front();
            check("snap_cycle", cyc, sp.at);
            check("load_h", int'(load_h), sp.h);
            check("load_m", int'(load_m), sp.m);
            check("load_s", int'(load_s), sp.s);
        end
        if (load) begin
            if (load_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_load at cycle %0d: got load=1, expected 0", cyc);
            end else begin
                sp = load_q.pop_front();
                check("load_cycle", cyc, sp.at);
                check("commit_h", int'(load_h), sp.h);
                check("commit_m", int'(load_m), sp.m);
                check("commit_s", int'(load_s), sp.s);
            end
        end
    end

    task automatic step(input logic up);
        if (m_mode == 1) b_h = (b_h + (up ? 1 : 23)) % 24;
        else if (m_mode == 2) b_m = (b_m + (up ? 1 : 59)) % 60;
        else b_s = (b_s + (up ? 1 : 59)) % 60;
    endtask

    // Reference model: what one press (held for 'hold' cycles) does, landing at edge 'act'.
    task automatic model(input logic [2:0] k, input int act, input int hold);
        if (k[2]) begin
            if (m_mode == 0) begin
                b_h = int'(cur_h);
                b_m = int'(cur_m);
                b_s = int'(cur_s);
                m_mode = 1;
                ev_q.push_back(ev_t'{act, 1, -1});
            end else if (m_mode < 3) begin
                m_mode++;
                ev_q.push_back(ev_t'{act, m_mode, -1});
            end else begin
                m_mode = 0;
                load_q.push_back(snap_t'{act, b_h, b_m, b_s});
                ev_q.push_back(ev_t'{act, 0, act + 1});
            end
            snap_q.push_back(snap_t'{act, b_h, b_m, b_s});
        end else if (m_mode != 0 && k[1] != k[0]) begin
            step(k[1]);
            snap_q.push_back(snap_t'{act, b_h, b_m, b_s});
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
            for (int j = 0; RD + BD * j <= hold - 1; j++) begin
                step(k[1]);
                snap_q.push_back(snap_t'{act + RD + BD * j, b_h, b_m, b_s});
            end
`endif
        end else begin
            snap_q.push_back(snap_t'{act, b_h, b_m, b_s});
        end
    endtask

    task automatic press(input logic [2:0] k, input int hold);
        int act;
        @(negedge Clk);
        {key_mode, key_up, key_down} = k;
        @(posedge Clk);
        #1;
        act = cyc + 2;
        model(k, act, hold);
        repeat (hold - 1) @(posedge Clk);
        @(negedge Clk);
        {key_mode, key_up, key_down} = 3'b000;
        repeat (4) @(posedge Clk);
    endtask

    task automatic release_reset();
        @(posedge Clk);
        #2 reset_n = 1'b1;
        ev_q.push_back(ev_t'{0, 0, 0});
        snap_q.push_back(snap_t'{0, 0, 0, 0});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout at cycle %0d: got no end of test, expected summary", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check("rst_tick", int'(tick_1s), 0);
        check("rst_load", int'(load), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_blink", int'(blink), 0);
        check("rst_buf", int'({load_h, load_m, load_s}), 0);
        repeat (2) @(posedge Clk);
        release_reset();
        repeat (35) @(posedge Clk);

        cur_h = 5'd12; cur_m = 6'd34; cur_s = 6'd56;
        press(3'b100, 3);
        press(3'b100, 3);
        press(3'b100, 3);
        press(3'b100, 3);
        repeat (25) @(posedge Clk);

        cur_h = 5'd23; cur_m = 6'd0; cur_s = 6'd17;
        press(3'b010, 3);
        press(3'b100, 3);
        press(3'b010, 3);
        press(3'b001, 3);
        press(3'b110, 3);
        press(3'b001, 3);
        press(3'b011, 3);
        press(3'b101, 3);
        press(3'b010, 3);
        press(3'b100, 3);
        repeat (25) @(posedge Clk);

        for (int it = 0; it < 6; it++) begin
            cur_h = 5'($urandom_range(23));
            cur_m = 6'($urandom_range(59));
            cur_s = 6'($urandom_range(59));
            press(3'($urandom_range(1, 3)), 3);
            press(3'b100, 3);
            for (int f = 0; f < 3; f++) begin
                repeat ($urandom_range(2, 5)) press(3'($urandom_range(1, 3)), 3);
                press($urandom_range(3) == 0 ? 3'b110 : 3'b100, 3);
            end
            repeat ($urandom_range(5, 25)) @(posedge Clk);
        end

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
        cur_h = 5'd3; cur_m = 6'd4; cur_s = 6'd0;
        press(3'b100, 3);
        press(3'b100, 3);
        press(3'b100, 3);
        press(3'b010, 20);
        press(3'b100, 3);
        repeat (15) @(posedge Clk);
`endif

        cur_h = 5'd7; cur_m = 6'd8; cur_s = 6'd9;
        press(3'b100, 3);
        press(3'b100, 3);
        press(3'b010, 3);
        @(negedge Clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_tick", int'(tick_1s), 0);
        check("midrst_load", int'(load), 0);
        check("midrst_mode", int'(mode), 0);
        check("midrst_blink", int'(blink), 0);
        check("midrst_buf", int'({load_h, load_m, load_s}), 0);
        m_mode = 0; b_h = 0; b_m = 0; b_s = 0;
        repeat (2) @(posedge Clk);
        release_reset();
        repeat (25) @(posedge Clk);

        #1;
        check("load_q_left", load_q.size(), 0);
        check("snap_q_left", snap_q.size(), 0);
        check("ev_q_left", ev_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
